mem_stage: RTL

Pipeline MEM stage. Consumes the EX->MEM bundle (EXMEM_Pipe_t) and performs loads and stores over a 64-bit valid/grant/response data-memory port. Aligns and sign-extends load data, and registers the MEM->WB bundle (MEMWB_Pipe_Out_t). Stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/pipeline_pkg.sv | 68 ++++++
 rtl/mem_lane_align.sv | 36 +++
 rtl/mem_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types, constants and helpers for the MEM stage and its lane aligner.
// The misaligned-access trap is selected by defining MEM_MISALIGN_TRAP_EN.
package pipeline_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int RF_SIZE    = 5;

    localparam int IDX_RS1 = 0;
    localparam int IDX_RS2 = 1;
    localparam int IDX_RD  = 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                           enable;
        logic [DATA_WIDTH-1:0]          PC;
        logic [DATA_WIDTH-1:0]          PC_Next;
        logic [2:0][RF_SIZE-1:0]        RegIdx;
        logic                           Reg_WEn;
        logic                           Mem_REn;
        logic                           Mem_WEn;
        logic [2:0]                     Detail;
        logic [DATA_WIDTH-1:0]          ALU_Result;
        logic [DATA_WIDTH-1:0]          Store_Data;
    } EXMEM_Pipe_t;

    typedef struct packed {
        logic                           enable;
        logic [DATA_WIDTH-1:0]          PC;
        logic [DATA_WIDTH-1:0]          PC_Next;
        logic [RF_SIZE-1:0]             RD_Addr;
        logic                           Reg_WEn;
        logic                           Mem_REn;
        logic [DATA_WIDTH-1:0]          WB_Data;
    } MEMWB_Pipe_Out_t;

    // Detail[1:0] encodes the access size; 111 falls into the doubleword case.
    function automatic logic [7:0] size_mask(input logic [2:0] detail);
        case (detail[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] detail, input logic [2:0] offset);
        case (detail[1:0])
            2'b00:   return 1'b0;
            2'b01:   return offset[0];
            2'b10:   return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/strobe placement and load shift/extension.
// Lanes past byte 7 are dropped by truncation; nothing wraps into the next word.
module mem_lane_align
    import pipeline_pkg::*;
(
    input  logic [2:0]            detail,
    input  logic [2:0]            offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [7:0]            wstrb,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [5:0]            bit_shift;
    logic [DATA_WIDTH-1:0] shifted;

    assign bit_shift = {offset, 3'b000};
    assign wstrb     = size_mask(detail) << offset;
    assign wdata     = store_data << bit_shift;
    assign shifted   = rdata >> bit_shift;

    always_comb begin
        load_data = shifted;
        case (detail)
            F3_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_data = {56'b0, shifted[7:0]};
            F3_HU:   load_data = {48'b0, shifted[15:0]};
            F3_WU:   load_data = {32'b0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on a valid/grant/response port and registers MEM->WB.
// Define MEM_MISALIGN_TRAP_EN to trap size-misaligned accesses instead of issuing them.
module mem_stage
    import pipeline_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  EXMEM_Pipe_t           ex_mem_i,
    output logic                  stall_o,
    output MEMWB_Pipe_Out_t       mem_wb_o,
    output logic                  dmem_req_o,
    input  logic                  dmem_gnt_i,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [7:0]            dmem_wstrb_o,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  mem_misalign_o
);

    mem_state_t            state, state_next;
    logic                  mem_op;
    logic                  trap;
    logic                  issue;
    logic [7:0]            lane_wstrb;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  unused_bits;

    assign mem_op = ex_mem_i.enable & (ex_mem_i.Mem_REn | ex_mem_i.Mem_WEn);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op & is_misaligned(ex_mem_i.Detail, ex_mem_i.ALU_Result[2:0]);
`else
    assign trap = 1'b0;
`endif

    // Gated by rst_n so the bus stays quiet while reset is held.
    assign issue = rst_n & (state == IDLE) & mem_op & ~trap;

    assign unused_bits = ^{ex_mem_i.RegIdx[IDX_RS1], ex_mem_i.RegIdx[IDX_RS2]};

    mem_lane_align u_align (
        .detail     (ex_mem_i.Detail),
        .offset     (ex_mem_i.ALU_Result[2:0]),
        .store_data (ex_mem_i.Store_Data),
        .rdata      (dmem_rdata_i),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // An rvalid coinciding with the grant is only ever seen outside WAIT_RSP, so it is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (issue) state_next = dmem_gnt_i ? WAIT_RSP : REQ;
            REQ:      if (dmem_gnt_i) state_next = WAIT_RSP;
            WAIT_RSP: if (dmem_rvalid_i) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o   = issue | (rst_n & (state == REQ));
        stall_o      = dmem_req_o | (rst_n & (state == WAIT_RSP) & ~dmem_rvalid_i);
        dmem_we_o    = dmem_req_o & ex_mem_i.Mem_WEn;
        dmem_addr_o  = '0;
        dmem_wstrb_o = '0;
        dmem_wdata_o = '0;
        if (dmem_req_o) begin
            dmem_addr_o  = {ex_mem_i.ALU_Result[DATA_WIDTH-1:3], 3'b000};
            dmem_wstrb_o = lane_wstrb;
        end
        if (dmem_we_o) dmem_wdata_o = lane_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_o <= '0;
        end else if (stall_o) begin
            mem_wb_o.enable <= 1'b0;
        end else if (state == WAIT_RSP) begin
            // Response cycle: the held EX/MEM bundle still describes the access.
            mem_wb_o.enable  <= 1'b1;
            mem_wb_o.PC      <= ex_mem_i.PC;
            mem_wb_o.PC_Next <= ex_mem_i.PC_Next;
            mem_wb_o.RD_Addr <= ex_mem_i.RegIdx[IDX_RD];
            if (ex_mem_i.Mem_WEn) begin
                mem_wb_o.Reg_WEn <= 1'b0;
                mem_wb_o.Mem_REn <= 1'b0;
                mem_wb_o.WB_Data <= '0;
            end else begin
                mem_wb_o.Reg_WEn <= ex_mem_i.Reg_WEn;
                mem_wb_o.Mem_REn <= 1'b1;
                mem_wb_o.WB_Data <= load_data;
            end
        end else if (!ex_mem_i.enable) begin
            mem_wb_o.enable  <= 1'b0;
            mem_wb_o.Reg_WEn <= 1'b0;
        end else begin
            mem_wb_o.enable  <= 1'b1;
            mem_wb_o.PC      <= ex_mem_i.PC;
            mem_wb_o.PC_Next <= ex_mem_i.PC_Next;
            mem_wb_o.RD_Addr <= ex_mem_i.RegIdx[IDX_RD];
            mem_wb_o.Reg_WEn <= ex_mem_i.Reg_WEn & ~trap;
            mem_wb_o.Mem_REn <= ex_mem_i.Mem_REn;
            mem_wb_o.WB_Data <= trap ? '0 : ex_mem_i.ALU_Result;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_misalign_o <= 1'b0;
        else        mem_misalign_o <= (state == IDLE) & trap;
    end
`else
    assign mem_misalign_o = 1'b0;
`endif

endmodule
